// File: rtl/layer_seq_pkg.sv
// rtl/layer_seq_pkg.sv - shared types and helpers for the layer sequencer
package layer_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Length vectors are widened to this fixed size so one helper serves every parameter set.
  localparam int MAX_LAYERS = 16;
  localparam int MAX_LEN_W  = 32;
  localparam int LEN_VEC_W  = MAX_LAYERS * MAX_LEN_W;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_LEN_W-1:0] len_of(input logic [LEN_VEC_W-1:0] lens,
                                                  input int len_w, input int idx);
    logic [LEN_VEC_W-1:0] sh;
    logic [MAX_LEN_W-1:0] f;
    sh = lens >> (idx * len_w);
    for (int b = 0; b < MAX_LEN_W; b++) begin
      f[b] = (b < len_w) ? sh[b] : 1'b0;
    end
    return f;
  endfunction

endpackage

// File: rtl/layer_addr_counter.sv
// rtl/layer_addr_counter.sv - saturating address counter shared by all layers
module layer_addr_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         saturated
);

  assign saturated = (count >= limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !saturated) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - runs NUM_LAYERS compute layers in order with abort and watchdog
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int                          NUM_LAYERS = 3,
  parameter int                          ADDR_W     = 32,
  parameter int                          LEN_W      = 16,
  parameter logic [NUM_LAYERS*LEN_W-1:0] LAYER_LEN  = {16'd32, 16'd128, 16'd784},
  parameter int                          TIMEOUT    = 4096
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [NUM_LAYERS-1:0]                layer_done,
  output logic [NUM_LAYERS-1:0]                layer_run,
  output logic [ADDR_W-1:0]                    addr,
  output logic [idx_width(NUM_LAYERS)-1:0]     layer_idx,
  output logic                                 busy,
  output logic                                 net_done,
  output logic                                 timeout_err
);

  localparam int                    IDX_W   = idx_width(NUM_LAYERS);
  localparam logic [LEN_VEC_W-1:0]  LEN_VEC = LEN_VEC_W'(LAYER_LEN);
  localparam logic [IDX_W-1:0]      LAST    = IDX_W'(NUM_LAYERS - 1);

  state_t                state, state_next;
  logic [IDX_W-1:0]      idx_next;
  logic [NUM_LAYERS-1:0] run_next;
  logic                  busy_next, net_done_next, terr_next;
  logic                  done_hit, timeout_hit, saturated;
  logic                  cnt_clr, cnt_en;
  logic [LEN_W-1:0]      len_field;
  logic [ADDR_W-1:0]     limit;

  always_comb begin
    len_field = LEN_W'(len_of(LEN_VEC, LEN_W, int'(layer_idx)));
    limit     = ADDR_W'(len_field - LEN_W'(1));
  end

  // layer_run is only non-zero in RUN, so masking with it selects the active layer's done bit.
  assign done_hit = |(layer_done & layer_run);
  assign cnt_en   = (state == RUN) && !saturated;
  assign cnt_clr  = (state != RUN) || (state_next != RUN);

  layer_addr_counter #(.W(ADDR_W)) u_addr (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .limit     (limit),
    .count     (addr),
    .saturated (saturated)
  );

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int WCNT_W = $clog2(TIMEOUT + 1);
      logic [WCNT_W-1:0] wait_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wait_cnt <= '0;
        end else if (cnt_clr) begin
          wait_cnt <= '0;
        end else if (saturated) begin
          wait_cnt <= wait_cnt + WCNT_W'(1);
        end
      end

      // Fires on the cycle whose edge would bring the count to TIMEOUT.
      assign timeout_hit = (state == RUN) && saturated && (wait_cnt == WCNT_W'(TIMEOUT - 1));
    end else begin : g_no_wdog
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = layer_idx;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next = RUN;
          idx_next   = '0;
        end
      end
      RUN: begin
        if (abort || timeout_hit) begin
          state_next = IDLE;
        end else if (done_hit) begin
          state_next = GAP;
        end
      end
      GAP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (layer_idx < LAST) begin
          state_next = RUN;
          idx_next   = layer_idx + IDX_W'(1);
        end else begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so nothing is combinational from inputs.
  always_comb begin
    run_next      = (state_next == RUN) ? (NUM_LAYERS'(1) << idx_next) : '0;
    busy_next     = (state_next != IDLE);
    net_done_next = (state_next == DONE);
    terr_next     = timeout_err;
    if ((state == IDLE) && start && !abort) begin
      terr_next = 1'b0;
    end
    if ((state == RUN) && timeout_hit && !abort) begin
      terr_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_run   <= '0;
      layer_idx   <= '0;
      busy        <= 1'b0;
      net_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      layer_run   <= run_next;
      layer_idx   <= idx_next;
      busy        <= busy_next;
      net_done    <= net_done_next;
      timeout_err <= terr_next;
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - scoreboard and scenario-table bench for layer_sequencer
module tb_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_a = 1'b0, abort_a = 1'b0;
  logic [2:0]  done_a = '0;
  logic [2:0]  run_a;
  logic [31:0] addr_a;
  logic [1:0]  idx_a;
  logic        busy_a, nd_a, terr_a;

  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [4:0]  done_b = '0;
  logic [4:0]  run_b;
  logic [31:0] addr_b;
  logic [2:0]  idx_b;
  logic        busy_b, nd_b, terr_b;

  layer_sequencer #(
    .NUM_LAYERS(3), .ADDR_W(32), .LEN_W(16),
    .LAYER_LEN({16'd32, 16'd128, 16'd784}), .TIMEOUT(16)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .layer_done(done_a),
    .layer_run(run_a), .addr(addr_a), .layer_idx(idx_a), .busy(busy_a),
    .net_done(nd_a), .timeout_err(terr_a)
  );

  layer_sequencer #(
    .NUM_LAYERS(5), .ADDR_W(32), .LEN_W(16),
    .LAYER_LEN({16'd5, 16'd4, 16'd3, 16'd2, 16'd1}), .TIMEOUT(0)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .layer_done(done_b),
    .layer_run(run_b), .addr(addr_b), .layer_idx(idx_b), .busy(busy_b),
    .net_done(nd_b), .timeout_err(terr_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    int          idx;
    int          addr;
    int          wcnt;
    bit          terr;
    bit          busy;
    bit          nd;
    logic [15:0] run;
  } m_t;

  typedef struct {
    int dut;
    int done_delay;
    int early;
    int skip;
    int abort_addr;
    bit stray;
    bit start_mid;
    int exp_nd;
    bit exp_terr;
    int mx0, mx1, mx2, mx3, mx4;
  } scen_t;

  int    lens_a[16];
  int    lens_b[16];
  m_t    ma, mb;
  m_t    qa[$];
  m_t    qb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  scen_t tbl[7];

  task automatic check(input string what, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", what, act, req);
    end
  endtask

  function automatic m_t model_reset();
    m_t r;
    r.st = 0; r.idx = 0; r.addr = 0; r.wcnt = 0;
    r.terr = 0; r.busy = 0; r.nd = 0; r.run = '0;
    return r;
  endfunction

  // Reference behaviour: state codes 0 IDLE, 1 RUN, 2 GAP, 3 DONE.
  function automatic m_t model_next(input m_t s, input bit st_in, input bit ab,
                                    input logic [15:0] dn, input int lens[16],
                                    input int n, input int to);
    m_t r;
    int lim;
    bit sat;
    r = s;
    case (s.st)
      0: if (!ab && st_in) begin
        r.st = 1; r.idx = 0; r.addr = 0; r.wcnt = 0; r.terr = 0;
      end
      1: begin
        lim = lens[s.idx] - 1;
        sat = (s.addr == lim);
        if (ab) begin
          r.st = 0; r.addr = 0; r.wcnt = 0;
        end else if (to != 0 && sat && s.wcnt + 1 == to) begin
          r.st = 0; r.addr = 0; r.wcnt = 0; r.terr = 1;
        end else if (dn[s.idx]) begin
          r.st = 2; r.addr = 0; r.wcnt = 0;
        end else if (sat) begin
          r.wcnt = s.wcnt + 1;
        end else begin
          r.addr = s.addr + 1;
        end
      end
      2: begin
        if (ab) r.st = 0;
        else if (s.idx < n - 1) begin
          r.st = 1; r.idx = s.idx + 1;
        end else r.st = 3;
      end
      default: r.st = 0;
    endcase
    r.run  = (r.st == 1) ? (16'd1 << r.idx) : 16'd0;
    r.busy = (r.st != 0);
    r.nd   = (r.st == 3);
    return r;
  endfunction

  task automatic step();
    m_t e;
    @(posedge clk);
    ma = model_next(ma, start_a, abort_a, {13'd0, done_a}, lens_a, 3, 16);
    mb = model_next(mb, start_b, abort_b, {11'd0, done_b}, lens_b, 5, 0);
    qa.push_back(ma);
    qb.push_back(mb);
    #1;
    cyc++;
    e = qa.pop_front();
    check("a_run",  int'(run_a),  int'(e.run));
    check("a_addr", int'(addr_a), e.addr);
    check("a_idx",  int'(idx_a),  e.idx);
    check("a_busy", int'(busy_a), int'(e.busy));
    check("a_net_done", int'(nd_a), int'(e.nd));
    check("a_timeout_err", int'(terr_a), int'(e.terr));
    e = qb.pop_front();
    check("b_run",  int'(run_b),  int'(e.run));
    check("b_addr", int'(addr_b), e.addr);
    check("b_idx",  int'(idx_b),  e.idx);
    check("b_busy", int'(busy_b), int'(e.busy));
    check("b_net_done", int'(nd_b), int'(e.nd));
    check("b_timeout_err", int'(terr_b), int'(e.terr));
  endtask

  task automatic run_scen(input int id, input scen_t sc);
    int n, lim, satc, sat_cyc, terr_cyc, ndc;
    int o_run, o_addr, o_idx, o_busy, o_nd, o_terr;
    int mx[5];
    int req[5];
    bit fin, ab, stt;
    logic [4:0] dn;
    m_t m;
    n = sc.dut ? 5 : 3;
    req = '{sc.mx0, sc.mx1, sc.mx2, sc.mx3, sc.mx4};
    for (int i = 0; i < 5; i++) mx[i] = -1;
    satc = 0; sat_cyc = -1; terr_cyc = -1; ndc = 0; fin = 0;

    if (sc.dut) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0; start_b = 1'b0;
    check("start_clears_timeout_err", sc.dut ? int'(terr_b) : int'(terr_a), 0);

    for (int c = 0; c < 3000 && !fin; c++) begin
      m = sc.dut ? mb : ma;
      dn = '0; ab = 0; stt = 0; lim = 0;
      if (m.st == 1) begin
        lim = (sc.dut ? lens_b[m.idx] : lens_a[m.idx]) - 1;
        if (m.idx != sc.skip) begin
          if (sc.early >= 0 && m.addr == sc.early) dn[m.idx] = 1'b1;
          if (m.addr == lim) begin
            if (satc == sc.done_delay) dn[m.idx] = 1'b1;
            satc++;
          end else satc = 0;
        end
        if (sc.stray && m.idx == 0 && m.addr == 5) dn[2] = 1'b1;
        if (sc.start_mid && m.idx == 1 && m.addr == 10) stt = 1;
        if (sc.abort_addr >= 0 && m.idx == 0 && m.addr == sc.abort_addr) begin
          ab = 1; dn[0] = 1'b1;
        end
      end else satc = 0;

      if (sc.dut) begin
        start_b = stt; abort_b = ab; done_b = dn;
      end else begin
        start_a = stt; abort_a = ab; done_a = dn[2:0];
      end
      step();
      start_a = 1'b0; abort_a = 1'b0; done_a = '0;
      start_b = 1'b0; abort_b = 1'b0; done_b = '0;

      o_run  = sc.dut ? int'(run_b)  : int'(run_a);
      o_addr = sc.dut ? int'(addr_b) : int'(addr_a);
      o_idx  = sc.dut ? int'(idx_b)  : int'(idx_a);
      o_busy = sc.dut ? int'(busy_b) : int'(busy_a);
      o_nd   = sc.dut ? int'(nd_b)   : int'(nd_a);
      o_terr = sc.dut ? int'(terr_b) : int'(terr_a);
      if (o_run != 0 && o_idx < 5 && o_addr > mx[o_idx]) mx[o_idx] = o_addr;
      if (o_nd != 0) ndc++;
      if (sc.skip >= 0 && o_run != 0 && o_idx == sc.skip &&
          o_addr == lens_a[sc.skip] - 1 && sat_cyc < 0) sat_cyc = cyc;
      if (o_terr != 0 && terr_cyc < 0) terr_cyc = cyc;
      if (ab) begin
        check("abort_busy", o_busy, 0);
        check("abort_addr", o_addr, 0);
        check("abort_net_done", o_nd, 0);
      end
      m = sc.dut ? mb : ma;
      if (m.st == 0) fin = 1;
    end

    check("pass_ends_within_bound", int'(fin), 1);
    step();
    step();
    $display("scenario %0d net_done count %0d", id, ndc);
    check("net_done_count", ndc, sc.exp_nd);
    check("timeout_err_final", sc.dut ? int'(terr_b) : int'(terr_a), int'(sc.exp_terr));
    for (int i = 0; i < n; i++) check("layer_last_addr", mx[i], req[i]);
    if (sc.skip >= 0) check("timeout_latency", terr_cyc - sat_cyc, 16);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      lens_a[i] = 1;
      lens_b[i] = 1;
    end
    lens_a[0] = 784; lens_a[1] = 128; lens_a[2] = 32;
    for (int i = 0; i < 5; i++) lens_b[i] = i + 1;

    // dut done_delay early skip abort stray start_mid exp_nd exp_terr max-addr per layer
    tbl[0] = '{0, 5, -1, -1, -1,  0, 0, 1, 0, 783, 127, 31, -1, -1};
    tbl[1] = '{1, 2, -1, -1, -1,  0, 0, 1, 0, 0, 1, 2, 3, 4};
    tbl[2] = '{0, 5, -1,  1, -1,  0, 0, 0, 1, 783, 127, -1, -1, -1};
    tbl[3] = '{0, 0, -1, -1, -1,  0, 0, 1, 0, 783, 127, 31, -1, -1};
    tbl[4] = '{0, 5, -1, -1, 400, 0, 0, 0, 0, 400, -1, -1, -1, -1};
    tbl[5] = '{0, 5, -1, -1, -1,  1, 1, 1, 0, 783, 127, 31, -1, -1};
    tbl[6] = '{0, 5, 10, -1, -1,  0, 0, 1, 0, 10, 10, 10, -1, -1};

    #12;
    check("reset_run",  int'(run_a),  0);
    check("reset_addr", int'(addr_a), 0);
    check("reset_idx",  int'(idx_a),  0);
    check("reset_busy", int'(busy_a), 0);
    check("reset_net_done", int'(nd_a), 0);
    check("reset_timeout_err", int'(terr_a), 0);
    check("reset_b_busy", int'(busy_b), 0);
    #10;
    rst = 1'b0;
    ma = model_reset();
    mb = model_reset();

    for (int t = 0; t < 7; t++) run_scen(t, tbl[t]);

    // Asynchronous reset in the middle of layer 1.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 0; c < 2000 && !(ma.st == 1 && ma.idx == 1); c++) begin
      if (ma.st == 1 && ma.addr == lens_a[ma.idx] - 1) done_a = 3'(1 << ma.idx);
      step();
      done_a = '0;
    end
    check("reached_layer1", int'(idx_a), 1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_run",  int'(run_a),  0);
    check("async_rst_addr", int'(addr_a), 0);
    check("async_rst_idx",  int'(idx_a),  0);
    check("async_rst_busy", int'(busy_a), 0);
    check("async_rst_net_done", int'(nd_a), 0);
    check("async_rst_timeout_err", int'(terr_a), 0);
    ma = model_reset();
    mb = model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("restart_run", int'(run_a), 1);
    check("restart_addr", int'(addr_a), 0);
    step();
    step();
    check("restart_addr_sweep", int'(addr_a), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
